// File: rtl/adc_sample_ctrl.sv
// APB-attached ADC sampling controller: triggers conversions (single-shot or
// periodic), waits for conversion-done, and captures the result for bus readback.
module adc_sample_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TRIG_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  adc_trigger,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_done,
    output logic                  irq
);

    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TRW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRIG    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [TRW-1:0]        trig_cnt_q, trig_cnt_d;
    logic [TOW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [DATA_WIDTH-1:0] period_q, period_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  enable_q, enable_d, cont_q, cont_d;
    logic                  ie_valid_q, ie_valid_d, ie_err_q, ie_err_d;
    logic                  valid_q, valid_d, overrun_q, overrun_d, timeout_q, timeout_d;
    logic                  done_pend_q, done_pend_d, run_prev_q;
    logic                  trigger_q, trigger_d, irq_q, irq_d;

    logic wr_s, ctrl_wr_s, period_wr_s, status_wr_s, data_rd_s;
    logic en_eff_s, start_s, busy_s, run_s, expired_s, capture_s, timeout_set_s;
    logic [DATA_WIDTH-1:0] reload_s;
    logic unused_s;

    assign wr_s        = psel & penable & pwrite;
    assign ctrl_wr_s   = wr_s & (paddr[3:2] == 2'd0);
    assign period_wr_s = wr_s & (paddr[3:2] == 2'd1);
    assign status_wr_s = wr_s & (paddr[3:2] == 2'd2);
    assign data_rd_s   = psel & penable & ~pwrite & (paddr[3:2] == 2'd3);
    // A CTRL write takes effect on the FSM in the same cycle it is written.
    assign en_eff_s    = ctrl_wr_s ? pwdata[0] : enable_q;
    assign start_s     = ctrl_wr_s & pwdata[2];
    assign busy_s      = (state_q != ST_IDLE);
    assign run_s       = enable_q & cont_q;
    assign expired_s   = run_s & run_prev_q & (per_cnt_q == '0);
    assign reload_s    = (period_q == '0) ? '0 : period_q - DATA_WIDTH'(1);
    assign pready      = 1'b1;
    assign adc_trigger = trigger_q;
    assign irq         = irq_q;
    assign unused_s    = ^paddr[1:0];

    // Conversion sequencer next-state logic
    always_comb begin
        state_d       = state_q;
        trig_cnt_d    = trig_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        done_pend_d   = done_pend_q;
        sample_d      = sample_q;
        capture_s     = 1'b0;
        timeout_set_s = 1'b0;
        if (busy_s && !en_eff_s) begin
            state_d     = ST_IDLE;
            done_pend_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_pend_d = 1'b0;
                    if (en_eff_s && (start_s || expired_s)) begin
                        state_d    = ST_TRIG;
                        trig_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TRIG: begin
                    if (adc_done) begin
                        done_pend_d = 1'b1;
                        sample_d    = adc_data;
                    end else begin
                        done_pend_d = done_pend_q;
                    end
                    if (trig_cnt_q == TRW'(TRIG_CYCLES - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = (done_pend_q || adc_done) ? ST_CAPTURE : ST_WAIT;
                    end else begin
                        trig_cnt_d = trig_cnt_q + TRW'(1);
                    end
                end
                ST_WAIT: begin
                    if (adc_done) begin
                        sample_d = adc_data;
                        state_d  = ST_CAPTURE;
                    end else if (wait_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_set_s = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TOW'(1);
                    end
                end
                ST_CAPTURE: begin
                    capture_s   = 1'b1;
                    done_pend_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Register file, period counter and output next-state
    always_comb begin
        enable_d   = ctrl_wr_s ? pwdata[0] : enable_q;
        cont_d     = ctrl_wr_s ? pwdata[1] : cont_q;
        ie_valid_d = ctrl_wr_s ? pwdata[3] : ie_valid_q;
        ie_err_d   = ctrl_wr_s ? pwdata[4] : ie_err_q;
        period_d   = period_wr_s ? pwdata : period_q;
        data_d     = capture_s ? sample_q : data_q;
        if (capture_s) begin
            valid_d = 1'b1;
        end else if (data_rd_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // A read landing on the capture cycle consumes the old sample, so no overrun.
        if (capture_s && valid_q && !data_rd_s) begin
            overrun_d = 1'b1;
        end else if (status_wr_s && pwdata[2]) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (timeout_set_s) begin
            timeout_d = 1'b1;
        end else if (status_wr_s && pwdata[3]) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
        if ((run_s && !run_prev_q) || expired_s) begin
            per_cnt_d = reload_s;
        end else if (run_s) begin
            per_cnt_d = per_cnt_q - DATA_WIDTH'(1);
        end else begin
            per_cnt_d = per_cnt_q;
        end
        trigger_d = (state_d == ST_TRIG);
        irq_d     = (valid_d & ie_valid_d) | ((overrun_d | timeout_d) & ie_err_d);
    end

    // APB read mux
    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (paddr[3:2])
                2'd0:    prdata[4:0] = {ie_err_q, ie_valid_q, 1'b0, cont_q, enable_q};
                2'd1:    prdata = period_q;
                2'd2:    prdata[3:0] = {timeout_q, overrun_q, valid_q, busy_s};
                2'd3:    prdata = data_q;
                default: prdata = '0;
            endcase
        end else begin
            prdata = '0;
        end
    end

    // State and register update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            trig_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            per_cnt_q   <= '0;
            period_q    <= '0;
            data_q      <= '0;
            sample_q    <= '0;
            enable_q    <= 1'b0;
            cont_q      <= 1'b0;
            ie_valid_q  <= 1'b0;
            ie_err_q    <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            done_pend_q <= 1'b0;
            run_prev_q  <= 1'b0;
            trigger_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_cnt_q  <= trig_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            per_cnt_q   <= per_cnt_d;
            period_q    <= period_d;
            data_q      <= data_d;
            sample_q    <= sample_d;
            enable_q    <= enable_d;
            cont_q      <= cont_d;
            ie_valid_q  <= ie_valid_d;
            ie_err_q    <= ie_err_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            done_pend_q <= done_pend_d;
            run_prev_q  <= run_s;
            trigger_q   <= trigger_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed testbench for adc_sample_ctrl with a latency-programmable ADC responder.
module tb_adc_sample_ctrl;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]    paddr = 4'h0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata, adc_data;
    logic          pready, adc_trigger, adc_done, irq;

    logic          model_en = 1'b0, model_done = 1'b0, trig_prev = 1'b0;
    int            model_lat = 0, lat_cnt = 0;
    logic [DW-1:0] model_data = '0, man_data = '0;
    logic          man_done = 1'b0;
    int            pass_cnt = 0, total_cnt = 0, cyc = 0;
    logic [DW-1:0] rd;
    int            t1, t2;

    assign adc_done = model_done | man_done;
    assign adc_data = man_done ? man_data : model_data;

    adc_sample_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(1024), .TRIG_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .adc_trigger(adc_trigger), .adc_data(adc_data), .adc_done(adc_done), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC responder: done strobe model_lat cycles after each trigger rising edge
    always @(negedge clk) begin
        model_done = 1'b0;
        if (model_en) begin
            if (adc_trigger && !trig_prev) begin
                lat_cnt = model_lat;
            end else if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) model_done = 1'b1;
            end
        end else begin
            lat_cnt = 0;
        end
        trig_prev = adc_trigger;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic apb_write(input logic [3:0] a, input logic [DW-1:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [DW-1:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk); penable = 1'b1;
        #1 d = prdata;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_rise(output int t);
        logic prev;
        int   i;
        prev = adc_trigger; t = -1; i = 0;
        while (t < 0 && i < 300) begin
            @(negedge clk);
            if (adc_trigger && !prev) t = cyc;
            prev = adc_trigger;
            i++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        pwdata = '0; man_done = 1'b0; man_data = '0; model_en = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b0; @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if (adc_trigger !== 1'b0) $display("FAIL rst_trigger: got %b expected 0", adc_trigger); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", irq); else pass_cnt++;
        total_cnt++; if (pready !== 1'b1) $display("FAIL rst_pready: got %b expected 1", pready); else pass_cnt++;
        total_cnt++; if (prdata !== 32'h0) $display("FAIL rst_prdata_idle: got %h expected 0", prdata); else pass_cnt++;
        @(negedge clk); reset = 1'b0; @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            apb_read(4'(r * 4), rd);
            total_cnt++; if (rd !== 32'h0) $display("FAIL rst_reg%0d: got %h expected 0", r, rd); else pass_cnt++;
        end
    endtask

    task automatic test_single_shot();
        do_reset();
        model_en = 1'b1; model_lat = 10; model_data = 32'h0000_0ABC;
        apb_write(4'h0, 32'h5);
        total_cnt++; if (adc_trigger !== 1'b1) $display("FAIL ss_trig_c1: got %b expected 1", adc_trigger); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (adc_trigger !== 1'b1) $display("FAIL ss_trig_c2: got %b expected 1", adc_trigger); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (adc_trigger !== 1'b0) $display("FAIL ss_trig_c3: got %b expected 0", adc_trigger); else pass_cnt++;
        repeat (15) @(negedge clk);
        apb_read(4'h0, rd);
        total_cnt++; if (rd !== 32'h1) $display("FAIL ss_ctrl_rb: got %h expected 1", rd); else pass_cnt++;
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h2) $display("FAIL ss_status_valid: got %h expected 2", rd); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL ss_irq: got %b expected 0", irq); else pass_cnt++;
        apb_read(4'hC, rd);
        total_cnt++; if (rd !== 32'hABC) $display("FAIL ss_data: got %h expected abc", rd); else pass_cnt++;
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h0) $display("FAIL ss_status_clr: got %h expected 0", rd); else pass_cnt++;
    endtask

    task automatic test_done_in_trig();
        do_reset();
        apb_write(4'h0, 32'h5);
        man_data = 32'h333; man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        repeat (6) @(negedge clk);
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h2) $display("FAIL trigdone_status: got %h expected 2", rd); else pass_cnt++;
        apb_read(4'hC, rd);
        total_cnt++; if (rd !== 32'h333) $display("FAIL trigdone_data: got %h expected 333", rd); else pass_cnt++;
    endtask

    task automatic test_continuous();
        do_reset();
        model_en = 1'b1; model_lat = 5; model_data = 32'h77;
        apb_write(4'h4, 32'd50);
        apb_write(4'h0, 32'h13);
        wait_rise(t1);
        total_cnt++; if (t1 < 0) $display("FAIL cont_first_trig: got no trigger expected trigger"); else pass_cnt++;
        repeat (12) @(negedge clk);
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h2) $display("FAIL cont_status1: got %h expected 2", rd); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL cont_irq1: got %b expected 0", irq); else pass_cnt++;
        wait_rise(t2);
        total_cnt++; if (t2 - t1 != 50) $display("FAIL cont_period: got %0d expected 50", t2 - t1); else pass_cnt++;
        repeat (12) @(negedge clk);
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h6) $display("FAIL cont_overrun: got %h expected 6", rd); else pass_cnt++;
        total_cnt++; if (irq !== 1'b1) $display("FAIL cont_irq2: got %b expected 1", irq); else pass_cnt++;
        apb_write(4'h0, 32'h0);
        apb_write(4'h8, 32'h4);
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h2) $display("FAIL cont_w1c: got %h expected 2", rd); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        model_en = 1'b1; model_lat = 3; model_data = 32'h1234_5678;
        apb_write(4'h0, 32'h5);
        repeat (15) @(negedge clk);
        model_en = 1'b0;
        apb_write(4'h0, 32'h15);
        repeat (1025) @(negedge clk);
        total_cnt++; if (irq !== 1'b0) $display("FAIL to_irq_early: got %b expected 0", irq); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (irq !== 1'b1) $display("FAIL to_irq_set: got %b expected 1", irq); else pass_cnt++;
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'hA) $display("FAIL to_status: got %h expected a", rd); else pass_cnt++;
        apb_read(4'hC, rd);
        total_cnt++; if (rd !== 32'h1234_5678) $display("FAIL to_data: got %h expected 12345678", rd); else pass_cnt++;
        apb_write(4'h8, 32'h8);
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h0) $display("FAIL to_w1c: got %h expected 0", rd); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL to_irq_clr: got %b expected 0", irq); else pass_cnt++;
    endtask

    task automatic test_collision();
        do_reset();
        model_en = 1'b1; model_lat = 3; model_data = 32'h111;
        apb_write(4'h0, 32'h5);
        repeat (15) @(negedge clk);
        model_en = 1'b0;
        apb_write(4'h0, 32'h5);
        repeat (3) @(negedge clk);
        man_data = 32'h222; man_done = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'hC;
        @(negedge clk); man_done = 1'b0; penable = 1'b1;
        #1 rd = prdata;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
        total_cnt++; if (rd !== 32'h111) $display("FAIL coll_old_data: got %h expected 111", rd); else pass_cnt++;
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h2) $display("FAIL coll_status: got %h expected 2", rd); else pass_cnt++;
        apb_read(4'hC, rd);
        total_cnt++; if (rd !== 32'h222) $display("FAIL coll_new_data: got %h expected 222", rd); else pass_cnt++;
    endtask

    task automatic test_abort();
        do_reset();
        apb_write(4'h0, 32'h5);
        repeat (3) @(negedge clk);
        apb_write(4'h0, 32'h0);
        total_cnt++; if (adc_trigger !== 1'b0) $display("FAIL abort_trig: got %b expected 0", adc_trigger); else pass_cnt++;
        man_data = 32'h444; man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        repeat (4) @(negedge clk);
        apb_read(4'h8, rd);
        total_cnt++; if (rd !== 32'h0) $display("FAIL abort_status: got %h expected 0", rd); else pass_cnt++;
        apb_read(4'hC, rd);
        total_cnt++; if (rd !== 32'h0) $display("FAIL abort_data: got %h expected 0", rd); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        apb_write(4'h4, 32'd7);
        apb_write(4'h0, 32'h1D);
        total_cnt++; if (adc_trigger !== 1'b1) $display("FAIL arst_pre_trig: got %b expected 1", adc_trigger); else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++; if (adc_trigger !== 1'b0) $display("FAIL arst_trig: got %b expected 0", adc_trigger); else pass_cnt++;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 4'h4;
        #1;
        total_cnt++; if (prdata !== 32'h0) $display("FAIL arst_period: got %h expected 0", prdata); else pass_cnt++;
        paddr = 4'h0;
        #1;
        total_cnt++; if (prdata !== 32'h0) $display("FAIL arst_ctrl: got %h expected 0", prdata); else pass_cnt++;
        @(negedge clk); psel = 1'b0; reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_done_in_trig();
        test_continuous();
        test_timeout();
        test_collision();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
Name: adc_sample_ctrl

Overview:
APB-attached ADC sampling controller that sits directly upstream of the ADC model. It drives the ADC trigger, waits for conversion-done, and captures the measurement into a bus-readable data register. Supports software single-shot and timer-driven continuous sampling, with status, overrun/timeout flags and an interrupt.

Parameters:
DATA_WIDTH, 32, APB data width and ADC measurement width
TIMEOUT_CYCLES, 1024, max cycles to wait for adc_done before flagging timeout (>=2)
TRIG_CYCLES, 2, width of the adc_trigger pulse in clk cycles (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB write
paddr  input  4  byte address; paddr[3:2] selects register
pwdata  input  DATA_WIDTH  APB write data
prdata  output  DATA_WIDTH  APB read data
pready  output  1  APB ready, tied 1 (zero wait states)
adc_trigger  output  1  conversion start pulse to ADC
adc_data  input  DATA_WIDTH  ADC measurement result
adc_done  input  1  single-cycle conversion-complete strobe
irq  output  1  level interrupt: (valid & ie_valid) | ((overrun|timeout) & ie_err)

Behaviour:
- Registers (write on psel&penable&pwrite; read data combinational on psel&~pwrite):
  0x0 CTRL: [0] enable, [1] continuous, [2] start (write-1, self-clearing, reads 0), [3] ie_valid, [4] ie_err.
  0x4 PERIOD: sample period in cycles, continuous mode only; 0 treated as 1.
  0x8 STATUS (RO except W1C): [0] busy, [1] valid, [2] overrun (W1C), [3] timeout (W1C).
  0xC DATA (RO): last captured sample; APB read-access of DATA clears valid.
- Reset: all registers 0, FSM IDLE, adc_trigger 0, irq 0, prdata 0 when not selected.
- FSM states: IDLE, TRIG, WAIT, CAPTURE.
  IDLE -> TRIG when enable & (start written, or continuous & period counter expired). Both same cycle: one conversion only.
  TRIG: adc_trigger=1 for exactly TRIG_CYCLES cycles, then WAIT. Trigger goes high the cycle after the start write.
  WAIT: on adc_done -> CAPTURE; if TIMEOUT_CYCLES elapse without adc_done -> set timeout, -> IDLE, DATA unchanged.
  adc_done during TRIG is accepted (treated as arriving in WAIT). adc_done in IDLE ignored.
  CAPTURE (1 cycle): DATA <= adc_data sampled on the done cycle; if valid already 1 -> overrun=1; valid=1; -> IDLE.
- busy=1 in TRIG, WAIT, CAPTURE.
- Period counter: runs only when enable&continuous; reloads PERIOD-1 on reaching 0 and on entry to continuous mode; expiry while busy is dropped (no queuing), counted as neither overrun nor error.
- start written while busy: ignored.
- Capture and DATA read in same cycle: read returns old DATA, valid ends 1, no overrun.
- W1C of overrun/timeout coinciding with a new set event: set wins.
- Clearing enable mid-conversion: FSM -> IDLE next cycle, adc_trigger drops immediately, no capture, no flags.
- Async reset mid-operation: everything returns to reset values immediately.

Test Plan:
- Single shot: write CTRL=0x5; ADC returns done after 10 cycles with adc_data=0x0000_0ABC -> adc_trigger high 2 cycles starting cycle after write, STATUS=0x2, DATA reads 0xABC, then STATUS=0x0.
- Continuous: PERIOD=50, CTRL=0x3, done latency 5 -> triggers every 50 cycles; no DATA reads -> overrun set on 2nd capture, irq=1 with ie_err.
- Timeout: TIMEOUT_CYCLES=1024, start, never assert adc_done -> timeout=1 at cycle 1024 of WAIT, busy=0, DATA unchanged; W1C 0x8 clears it.
- Read/capture collision: DATA read coincides with CAPTURE -> old value returned, valid=1, overrun=0.
- Abort: clear enable during WAIT, then pulse adc_done -> no capture, valid=0, FSM IDLE.
- Async reset asserted during TRIG -> adc_trigger=0 and all registers 0 without a clock edge.
